puf_uart_ctrl: RTL

PUF_UART_CTRL -- requirements
Module: puf_uart_ctrl

---
 rtl/puf_uart_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/puf_uart_ctrl.sv
// PUF command controller behind a byte UART.
// 0xC5 + challenge bytes -> one PUF evaluation -> response bytes; anything else -> 0xEE.
module puf_uart_ctrl #(
  parameter int CHALLENGE_BYTES = 4,
  parameter int RESPONSE_BYTES  = 4,
  parameter int TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         rx_enable,
  output logic [7:0]                   tx_data,
  output logic                         tx_enable,
  input  logic                         tx_busy,
  output logic [8*CHALLENGE_BYTES-1:0] challenge,
  output logic                         puf_start,
  input  logic                         puf_done,
  input  logic [8*RESPONSE_BYTES-1:0]  puf_response,
  output logic                         busy
);

  localparam int CW = 8*CHALLENGE_BYTES;
  localparam int RW = 8*RESPONSE_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES-1);
  localparam logic [4:0] CB_LAST = 5'(CHALLENGE_BYTES-1);
  localparam logic [4:0] RB_NUM  = 5'(RESPONSE_BYTES);
  localparam logic [RW-1:0] ERR_Q = RW'(8'hEE) << (RW-8);

  typedef enum logic [2:0] {
    IDLE, RX_CHAL, PUF_RUN, TX_LOAD, TX_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   chal_q, chal_d;
  logic [RW-1:0]   txq_q, txq_d;
  logic [4:0]      bcnt_q, bcnt_d;
  logic [4:0]      qcnt_q, qcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            first_q, first_d;
  logic            start_q, start_d;
  logic [CW+7:0]   chal_sh;
  logic [TW-1:0]   tcnt_inc;
  logic            tmo;

  assign chal_sh  = {chal_q, rx_data};
  assign tmo      = (tcnt_q == TO_LAST);
  assign tcnt_inc = tmo ? tcnt_q : tcnt_q + TW'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      chal_q  <= '0;
      txq_q   <= '0;
      bcnt_q  <= '0;
      qcnt_q  <= '0;
      tcnt_q  <= '0;
      first_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chal_q  <= chal_d;
      txq_q   <= txq_d;
      bcnt_q  <= bcnt_d;
      qcnt_q  <= qcnt_d;
      tcnt_q  <= tcnt_d;
      first_q <= first_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chal_d  = chal_q;
    txq_d   = txq_q;
    bcnt_d  = bcnt_q;
    qcnt_d  = qcnt_q;
    tcnt_d  = tcnt_q;
    first_d = 1'b0;
    start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == 8'hC5) begin
            bcnt_d  = '0;
            tcnt_d  = '0;
            state_d = RX_CHAL;
          end else begin
            txq_d   = ERR_Q;
            qcnt_d  = 5'd1;
            state_d = TX_LOAD;
          end
        end
      end
      RX_CHAL: begin
        if (rx_valid) begin
          chal_d = chal_sh[CW-1:0];
          bcnt_d = bcnt_q + 5'd1;
          tcnt_d = '0;
          if (bcnt_q == CB_LAST) begin
            start_d = 1'b1;
            state_d = PUF_RUN;
          end
        end else if (tmo) begin
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      PUF_RUN: begin
        // a response arriving in the expiry cycle beats the timeout
        if (puf_done) begin
          txq_d   = puf_response;
          qcnt_d  = RB_NUM;
          state_d = TX_LOAD;
        end else if (tmo) begin
          txq_d   = ERR_Q;
          qcnt_d  = 5'd1;
          state_d = TX_LOAD;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      TX_LOAD: begin
        if (!tx_busy) begin
          first_d = 1'b1;
          state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // tx_busy may lag the send request by a cycle
        if (!first_q && !tx_busy) begin
          txq_d   = txq_q << 8;
          qcnt_d  = qcnt_q - 5'd1;
          state_d = (qcnt_q == 5'd1) ? IDLE : TX_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_data   = txq_q[RW-1 -: 8];
  assign tx_enable = (state_q == TX_LOAD) && !tx_busy;
  assign puf_start = start_q;
  assign challenge = chal_q;
  assign busy      = (state_q != IDLE);
  assign rx_enable = (state_q == IDLE) || (state_q == RX_CHAL);

endmodule
